// File: rtl/alu32_pkg.sv
// Shared types and constants for the gate-level ALU32 operand driver and its users.
package alu32_pkg;

  localparam int WIDTH = 32;
  localparam int OP_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             ci;
    logic [OP_W-1:0]  op;
  } req_t;

endpackage

// File: rtl/alu32_op_driver_settle_timer.sv
// Down-counter that times how long combinational inputs are held before sampling.
// Standalone (no package dependency) so other gate-level wrappers can reuse it.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  // A window shorter than one edge cannot resolve anything, so clamp to 1.
  localparam int EFF_CYCLES = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int TW         = (EFF_CYCLES > 1) ? $clog2(EFF_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(EFF_CYCLES - 1);

  logic [TW-1:0] count;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu32_op_driver.sv
// Valid/ready front end for the gate-level G_ALU32: registers a request onto the ALU
// inputs, waits out the carry-chain settle window, then captures and returns the result.
module alu32_op_driver #(
  parameter int WIDTH         = alu32_pkg::WIDTH,
  parameter int OP_W          = alu32_pkg::OP_W,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_in1,
  input  logic [WIDTH-1:0] req_in2,
  input  logic             req_ci,
  input  logic [OP_W-1:0]  req_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_ci,
  output logic [OP_W-1:0]  alu_a,
  input  logic [WIDTH-1:0] alu_cout,
  input  logic             alu_co,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_co,
  output logic [OP_W-1:0]  rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  alu32_pkg::state_t state, state_nxt;
  logic accept, capture, complete;
  logic timer_dec, timer_zero;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  (timer_dec),
    .zero (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= alu32_pkg::IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, otherwise synthesis infers latches.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    case (state)
      alu32_pkg::IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = alu32_pkg::SETTLE;
        end
      end
      alu32_pkg::SETTLE: begin
        if (timer_zero) begin
          capture   = 1'b1;
          state_nxt = alu32_pkg::RESP;
        end
      end
      alu32_pkg::RESP: begin
        if (rsp_ready) begin
          complete  = 1'b1;
          state_nxt = alu32_pkg::IDLE;
        end
      end
      default: state_nxt = alu32_pkg::IDLE;
    endcase
  end

  assign timer_dec = (state == alu32_pkg::SETTLE) && !timer_zero;
  assign req_ready = (state == alu32_pkg::IDLE);
  assign busy      = (state != alu32_pkg::IDLE);
  assign rsp_valid = (state == alu32_pkg::RESP);

  // ALU inputs only change on accept, so the gate-level carry chain never sees a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_ci   <= 1'b0;
      alu_a    <= '0;
      rsp_data <= '0;
      rsp_co   <= 1'b0;
      rsp_op   <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        alu_in1 <= req_in1;
        alu_in2 <= req_in2;
        alu_ci  <= req_ci;
        alu_a   <= req_op;
      end
      if (capture) begin
        rsp_data <= alu_cout;
        rsp_co   <= alu_co;
        rsp_op   <= alu_a;
      end
      if (complete) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu32_op_driver.sv
// Directed bench for alu32_op_driver with a behavioural add-only ALU stub and a result scoreboard.
module tb_alu32_op_driver;
  import alu32_pkg::*;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             co;
    logic [OP_W-1:0]  op;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_in1, req_in2;
  logic             req_ci;
  logic [OP_W-1:0]  req_op;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_cout;
  logic             alu_ci, alu_co;
  logic [OP_W-1:0]  alu_a;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_co;
  logic [OP_W-1:0]  rsp_op;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int   errors = 0;
  int   checks = 0;
  int   exp_count = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Stub ALU: every opcode performs In1 + In2 + CI.
  assign {alu_co, alu_cout} = {1'b0, alu_in1} + {1'b0, alu_in2} + 33'(alu_ci);

  alu32_op_driver #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_ci(req_ci), .req_op(req_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ci(alu_ci), .alu_a(alu_a),
    .alu_cout(alu_cout), .alu_co(alu_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_co(rsp_co), .rsp_op(rsp_op),
    .busy(busy), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send(input req_t r, input bit keep_valid);
    logic [32:0] sum;
    exp_t e;
    check("req_ready_before_send", req_ready, 1'b1);
    req_in1 = r.in1; req_in2 = r.in2; req_ci = r.ci; req_op = r.op;
    req_valid = 1'b1;
    sum = {1'b0, r.in1} + {1'b0, r.in2} + 33'(r.ci);
    e.data = sum[WIDTH-1:0]; e.co = sum[WIDTH]; e.op = r.op;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int lat;
    exp_t e;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, SETTLE);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, rsp_data, e.data);
      check({tag, "_co"}, rsp_co, e.co);
      check({tag, "_op"}, rsp_op, e.op);
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count++;
    check({tag, "_rsp_valid_drop"}, rsp_valid, 1'b0);
    check({tag, "_op_count"}, op_count, exp_count);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    int   sent, got, cyc, last;
    bit   saw_valid;
    req_t r;
    exp_t e;
    logic [32:0] sum;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_in1 = '0; req_in2 = '0; req_ci = 1'b0; req_op = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_op_count", op_count, 0);
    check("reset_alu_in1", alu_in1, 0);

    // Single operation.
    send('{in1: 32'd4325, in2: 32'd464, ci: 1'b0, op: 3'd0}, 1'b0);
    check("single_busy", busy, 1'b1);
    check("single_req_ready", req_ready, 1'b0);
    wait_rsp("single");
    check("single_data_const", rsp_data, 32'd4789);
    handshake("single");

    // Carry out, via In2 and via CI.
    send('{in1: 32'hFFFF_FFFF, in2: 32'd1, ci: 1'b0, op: 3'd5}, 1'b0);
    wait_rsp("carry_in2");
    check("carry_in2_co_const", rsp_co, 1'b1);
    handshake("carry_in2");
    send('{in1: 32'hFFFF_FFFF, in2: 32'd0, ci: 1'b1, op: 3'd2}, 1'b0);
    wait_rsp("carry_ci");
    check("carry_ci_data_const", rsp_data, 32'd0);
    handshake("carry_ci");

    // Backpressure: a competing request is held valid the whole time and must be ignored.
    send('{in1: 32'h1234_5678, in2: 32'h0101_0101, ci: 1'b1, op: 3'd6}, 1'b1);
    req_in1 = 32'hDEAD_BEEF; req_in2 = 32'hCAFE_F00D; req_op = 3'd1;
    wait_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_data", rsp_data, 32'h1335_577A);
      check("bp_alu_in1", alu_in1, 32'h1234_5678);
      check("bp_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    handshake("bp");
    check("bp_alu_hold", alu_in2, 32'h0101_0101);

    // Asynchronous reset mid-cycle while in SETTLE.
    send('{in1: 32'd7, in2: 32'd9, ci: 1'b0, op: 3'd4}, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_alu_in1", alu_in1, 0);
    check("rst_async_rsp_data", rsp_data, 0);
    check("rst_async_op_count", op_count, 0);
    check("rst_async_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    sb.delete();
    @(negedge clk);
    check("rst_release_req_ready", req_ready, 1'b1);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_valid |= rsp_valid;
      @(negedge clk);
    end
    check("rst_no_rsp_valid", saw_valid, 1'b0);
    check("rst_op_count", op_count, 0);
    send('{in1: 32'd100, in2: 32'd23, ci: 1'b1, op: 3'd7}, 1'b0);
    wait_rsp("after_rst");
    handshake("after_rst");

    // Opcode sweep, rsp_ready tied high, back-to-back requests.
    pulse_reset();
    rsp_ready = 1'b1;
    sent = 0; got = 0; cyc = 0; last = 0;
    while (got < 8 && cyc < 200) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("sweep_sb_empty", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("sweep_data", rsp_data, e.data);
          check("sweep_co", rsp_co, e.co);
          check("sweep_op", rsp_op, e.op);
        end
        if (got > 0) check("sweep_gap", cyc - last, SETTLE + 2);
        last = cyc;
        got++;
        exp_count++;
      end
      if (req_ready && sent < 8) begin
        r.in1 = $urandom; r.in2 = $urandom; r.ci = 1'($urandom_range(0, 1)); r.op = 3'(sent);
        req_in1 = r.in1; req_in2 = r.in2; req_ci = r.ci; req_op = r.op;
        req_valid = 1'b1;
        sum = {1'b0, r.in1} + {1'b0, r.in2} + 33'(r.ci);
        e.data = sum[WIDTH-1:0]; e.co = sum[WIDTH]; e.op = r.op;
        sb.push_back(e);
        sent++;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("sweep_got", got, 8);
    check("sweep_op_count", op_count, 8);
    check("sweep_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu32_op_driver.md
Name: alu32_op_driver

Overview:
Sequential front end that feeds operand/opcode requests into the gate-level 32-bit ALU (In1, In2, CI, A[2:0] → Cout, CO) and returns its results. Requests and responses both use valid/ready handshakes. Operands are held stable for a programmable settle window so the gate-level carry chain resolves before Cout/CO are sampled. Sits between a CPU/datapath controller and the G_ALU32 instance.

Parameters:
WIDTH, 32, operand/result width
OP_W, 3, opcode width (matches ALU A select)
SETTLE_CYCLES, 2, clock edges ALU inputs are held before sampling; values below 1 are treated as 1
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_in1  in  WIDTH  operand 1
req_in2  in  WIDTH  operand 2
req_ci  in  1  carry in
req_op  in  OP_W  ALU function select
alu_in1  out  WIDTH  to ALU In1
alu_in2  out  WIDTH  to ALU In2
alu_ci  out  1  to ALU CI
alu_a  out  OP_W  to ALU A
alu_cout  in  WIDTH  from ALU Cout
alu_co  in  1  from ALU CO
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_data  out  WIDTH  captured Cout
rsp_co  out  1  captured CO
rsp_op  out  OP_W  opcode that produced the result
busy  out  1  high in any state other than IDLE
op_count  out  CNT_W  completed (handshaken) responses

Behaviour:
- Reset (async assert, sync release): state IDLE; alu_in1/alu_in2/alu_a/alu_ci = 0; rsp_valid = 0; rsp_data/rsp_co/rsp_op = 0; op_count = 0; busy = 0; req_ready = 1 once reset is released.
- States: IDLE, SETTLE, RESP.
- IDLE: req_ready = 1, decoded from state only. On req_valid at an edge: register the request into alu_* outputs, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: req_ready = 0; alu_* held constant. Counter decrements each edge. At the edge where the counter is 0: capture alu_cout → rsp_data, alu_co → rsp_co, alu_a → rsp_op; set rsp_valid = 1; go to RESP.
- Latency: request accepted at edge N → rsp_valid high after edge N+SETTLE_CYCLES.
- RESP: rsp_valid = 1; rsp_* stable; req_ready = 0. On rsp_ready at an edge: rsp_valid → 0, op_count += 1, go to IDLE.
- Throughput: one operation per SETTLE_CYCLES+2 cycles when rsp_ready is tied high. A request is never accepted in the same cycle a response completes.
- alu_* keep the last operands after the response completes, until the next accept. Inputs are never glitched to 0.
- op_count wraps from all-ones to 0 with no flag.
- req_* values while req_ready = 0 are ignored. rsp_ready while rsp_valid = 0 is ignored.
- Reset mid-operation (SETTLE or RESP): in-flight result is discarded, all outputs return to reset values, and no rsp_valid pulse is produced.
- Opcode values are passed through unchanged. This block does not interpret them.

Decomposition:
- Package alu32_pkg: WIDTH and OP_W constants, state enum (IDLE, SETTLE, RESP), and a request struct {in1, in2, ci, op}.
- One sub-module is natural: settle_timer (load, decrement, zero flag, parameter SETTLE_CYCLES). It must be reusable by other gate-level wrappers.

Test Plan:
Bench connects a behavioural ALU stub (Cout/CO = In1+In2+CI for every op), SETTLE_CYCLES = 2.
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; req_ready = 1 on the first edge after release.
- Single op: In1 = 4325, In2 = 464, CI = 0, op = 3'b000 accepted at edge N → rsp_valid at N+2, rsp_data = 4789, rsp_co = 0, rsp_op = 0; op_count = 1 after the handshake.
- Carry out: In1 = 32'hFFFF_FFFF, In2 = 1, CI = 0 → rsp_data = 0, rsp_co = 1. Repeat with In2 = 0, CI = 1 → same result.
- Backpressure: rsp_ready held low 5 cycles → rsp_valid, rsp_data and alu_* stable; req_ready = 0 with req_valid high; completes on the first rsp_ready edge.
- Reset during SETTLE: accept a request, assert rst one cycle later → no rsp_valid ever; op_count = 0; next request completes normally.
- Opcode sweep: ops 0..7 back-to-back with rsp_ready = 1 → rsp_op matches in order, each response 4 cycles apart, op_count = 8.
